// File: rtl/axi_mgr_pkg.sv
// Shared types and constants for the single-beat AXI manager.
package axi_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } mgr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mgr_single.sv
// Single-beat AXI manager: one command/response transaction outstanding at a
// time, mapped onto AW/W/B or AR/R with a per-transaction timeout.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | AW/W/B in flight
// RD    | AR/R in flight
// RSP   | rsp_valid high, waiting for rsp_ready
module axi_mgr_single
    import axi_mgr_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  m_axi_clk,
    input  logic                  m_axi_reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    output logic                  m_axi_wlast,
    input  logic                  m_axi_wready,

    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rlast,
    output logic [1:0]            m_axi_rresp
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mgr_state_t       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_inc;
    logic             tmo_hit;

    logic aw_done, w_done, b_done, ar_done;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done_n, w_done_n, b_done_n, ar_done_n;

    // Single-beat transfers only, so rlast carries no information.
    logic unused_rlast;
    assign unused_rlast = m_axi_rlast;

    assign m_axi_rresp = RESP_OKAY;

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bready  & m_axi_bvalid;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rready  & m_axi_rvalid;

    assign aw_done_n = aw_done | aw_hs;
    assign w_done_n  = w_done  | w_hs;
    assign b_done_n  = b_done  | b_hs;
    assign ar_done_n = ar_done | ar_hs;

    assign tmo_inc = tmo_cnt + 1'b1;
    assign tmo_hit = (tmo_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge m_axi_clk) begin
        if (m_axi_reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            b_done        <= 1'b0;
            ar_done       <= 1'b0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_timeout   <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        rsp_write   <= cmd_write;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_OKAY;
                        rsp_timeout <= 1'b0;
                        tmo_cnt     <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        b_done      <= 1'b0;
                        ar_done     <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_wlast   <= 1'b1;
                            m_axi_bready  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            m_axi_rready  <= 1'b1;
                            state         <= RD;
                        end
                    end
                end

                WR: begin
                    tmo_cnt <= tmo_inc;
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        m_axi_wlast  <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // B may land before AW/W: the subordinate answers off the W beat.
                    if (b_hs) begin
                        m_axi_bready <= 1'b0;
                        b_done       <= 1'b1;
                        rsp_resp     <= m_axi_bresp;
                    end
                    if (aw_done_n && w_done_n && b_done_n) begin
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (tmo_hit) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_wlast   <= 1'b0;
                        m_axi_bready  <= 1'b0;
                        rsp_timeout   <= 1'b1;
                        rsp_resp      <= RESP_SLVERR;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end

                RD: begin
                    tmo_cnt <= tmo_inc;
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        ar_done       <= 1'b1;
                    end
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                    end
                    if (ar_done_n && r_hs) begin
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (tmo_hit) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b0;
                        rsp_timeout   <= 1'b1;
                        rsp_resp      <= RESP_SLVERR;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state         <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mgr_single.sv
// Directed bench for axi_mgr_single with a small behavioural AXI subordinate.
module tb_axi_mgr_single;

    logic       m_axi_clk = 1'b0;
    logic       m_axi_reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_resp;
    logic [7:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic       m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic       m_axi_bready, m_axi_bvalid, m_axi_arvalid, m_axi_arready;
    logic       m_axi_rready, m_axi_rvalid, m_axi_rlast;
    logic [1:0] m_axi_bresp, m_axi_rresp;

    always #5 m_axi_clk = ~m_axi_clk;

    axi_mgr_single #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .m_axi_clk(m_axi_clk), .m_axi_reset(m_axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wlast(m_axi_wlast),
        .m_axi_wready(m_axi_wready),
        .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp)
    );

    // Subordinate model: AW/W/AR always ready unless stalled, B one cycle
    // after the W beat, R one cycle after AR taken with rready.
    logic       aw_rdy_en, b_en, force_rd_en;
    logic [7:0] force_rd_val;
    logic [1:0] bresp_cfg;
    logic [7:0] mem [256];
    logic       b_pend, r_pend;
    logic [7:0] rdata_q, w_addr_q, w_data_q;
    int         wr_count;

    assign m_axi_awready = aw_rdy_en;
    assign m_axi_wready  = 1'b1;
    assign m_axi_arready = 1'b1;
    assign m_axi_bvalid  = b_pend;
    assign m_axi_bresp   = bresp_cfg;
    assign m_axi_rvalid  = r_pend;
    assign m_axi_rlast   = r_pend;
    assign m_axi_rdata   = rdata_q;

    always_ff @(posedge m_axi_clk) begin
        if (m_axi_reset) begin
            b_pend   <= 1'b0;
            r_pend   <= 1'b0;
            rdata_q  <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            wr_count <= 0;
        end else begin
            if (m_axi_wvalid && m_axi_wready) begin
                mem[m_axi_awaddr] <= m_axi_wdata;
                w_addr_q <= m_axi_awaddr;
                w_data_q <= m_axi_wdata;
                wr_count <= wr_count + 1;
                if (b_en) b_pend <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
            if (m_axi_arvalid && m_axi_arready && m_axi_rready) begin
                r_pend  <= 1'b1;
                rdata_q <= force_rd_en ? force_rd_val : mem[m_axi_araddr];
            end
            if (m_axi_rvalid && m_axi_rready) r_pend <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a posedge; accepted on the next posedge while in IDLE.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        @(posedge m_axi_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge m_axi_clk); #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_wait_bound", 32'(lat), 32'd0);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge m_axi_clk); #1;
        rsp_ready = 1'b0;
        chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] bresp;
        logic [7:0] exp_rdata;
        logic [1:0] exp_resp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         lat;
        logic [7:0] held_rdata;
        logic [1:0] held_resp;
        int         wc;

        vecs[0] = '{1'b1, 8'h12, 8'hA5, 2'b00, 8'h00, 2'b00};
        vecs[1] = '{1'b0, 8'h12, 8'h00, 2'b00, 8'hA5, 2'b00};
        vecs[2] = '{1'b1, 8'h34, 8'h3C, 2'b10, 8'h00, 2'b10};
        vecs[3] = '{1'b0, 8'h34, 8'h00, 2'b00, 8'h3C, 2'b00};
        vecs[4] = '{1'b1, 8'hFF, 8'h01, 2'b01, 8'h00, 2'b01};
        vecs[5] = '{1'b0, 8'hFF, 8'h00, 2'b00, 8'h01, 2'b00};

        m_axi_reset  = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        rsp_ready    = 1'b0;
        aw_rdy_en    = 1'b1;
        b_en         = 1'b1;
        force_rd_en  = 1'b0;
        force_rd_val = '0;
        bresp_cfg    = 2'b00;
        repeat (3) @(posedge m_axi_clk);
        #1;
        m_axi_reset = 1'b0;

        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                     m_axi_arvalid, m_axi_rready}), 32'd0);
        chk("reset_data", 32'({m_axi_awaddr, m_axi_wdata, m_axi_araddr, rsp_rdata}), 32'd0);
        chk("rresp_const", 32'(m_axi_rresp), 32'd0);

        // Back-to-back table: each read follows the write to the same address.
        for (int i = 0; i < 6; i++) begin
            bresp_cfg = vecs[i].bresp;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].wr)
                chk($sformatf("v%0d_aw_w_b_same", i),
                    32'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid}),
                    32'b11110);
            else
                chk($sformatf("v%0d_ar_r_same", i),
                    32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid}), 32'b110);
            chk($sformatf("v%0d_cmd_ready_low", i), 32'(cmd_ready), 32'd0);
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rsp_write", i), 32'(rsp_write), 32'(vecs[i].wr));
            chk($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_rsp_resp", i), 32'(rsp_resp), 32'(vecs[i].exp_resp));
            chk($sformatf("v%0d_rsp_timeout", i), 32'(rsp_timeout), 32'd0);
            if (vecs[i].wr)
                chk($sformatf("v%0d_sub_saw", i), 32'({w_addr_q, w_data_q}),
                    32'({vecs[i].addr, vecs[i].wdata}));
            finish_rsp();
        end
        bresp_cfg = 2'b00;

        // Read data supplied directly by the subordinate.
        force_rd_en  = 1'b1;
        force_rd_val = 8'h5A;
        issue(1'b0, 8'h12, 8'h00);
        wait_rsp(lat);
        chk("fread_rdata", 32'(rsp_rdata), 32'h5A);
        chk("fread_resp_write", 32'({rsp_resp, rsp_write}), 32'd0);
        finish_rsp();
        force_rd_en = 1'b0;

        // Response back-pressure: payload stable, new commands ignored.
        issue(1'b0, 8'h34, 8'h00);
        wait_rsp(lat);
        held_rdata = rsp_rdata;
        held_resp  = rsp_resp;
        chk("hold_first_rdata", 32'(held_rdata), 32'h3C);
        wc = wr_count;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h77;
        cmd_wdata = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            @(posedge m_axi_clk); #1;
            chk($sformatf("hold%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_payload", k), 32'({rsp_rdata, rsp_resp, rsp_write}),
                32'({held_rdata, held_resp, 1'b0}));
            chk($sformatf("hold%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("hold_no_aw", 32'({m_axi_awvalid, m_axi_wvalid}), 32'd0);
        chk("hold_no_write", 32'(wr_count), 32'(wc));
        finish_rsp();

        // Subordinate never answers B: forced completion after 16 cycles.
        b_en = 1'b0;
        issue(1'b1, 8'h40, 8'h99);
        wait_rsp(lat);
        chk("tmo_latency", 32'(lat), 32'd16);
        chk("tmo_flag", 32'(rsp_timeout), 32'd1);
        chk("tmo_resp", 32'(rsp_resp), 32'b10);
        chk("tmo_rdata", 32'(rsp_rdata), 32'd0);
        chk("tmo_axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready}), 32'd0);
        finish_rsp();
        b_en = 1'b1;

        // Reset in the middle of a write with AW stalled.
        aw_rdy_en = 1'b0;
        issue(1'b1, 8'h55, 8'h66);
        @(posedge m_axi_clk); #1;
        chk("rst_pre_awvalid", 32'(m_axi_awvalid), 32'd1);
        m_axi_reset = 1'b1;
        @(posedge m_axi_clk); #1;
        m_axi_reset = 1'b0;
        aw_rdy_en   = 1'b1;
        chk("rst_axi_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge m_axi_clk);
        #1;
        chk("rst_no_late_rsp", 32'(rsp_valid), 32'd0);

        // Normal operation resumes after reset.
        issue(1'b1, 8'h20, 8'hC3);
        wait_rsp(lat);
        chk("post_rst_write", 32'({lat[7:0], rsp_resp, rsp_timeout}), 32'({8'd2, 2'b00, 1'b0}));
        finish_rsp();
        issue(1'b0, 8'h20, 8'h00);
        wait_rsp(lat);
        chk("post_rst_read", 32'(rsp_rdata), 32'hC3);
        finish_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axi_mgr_single.md
Name: axi_mgr_single

Overview:
Single-beat AXI manager that turns a simple command/response interface into AXI AW/W/B and AR/R transactions. It sits directly upstream of the AXI subordinate interface and drives its s_axi_* ports from the test/CSR-access side of the FIFO design. One transaction is outstanding at a time, with a per-transaction timeout so that a stuck subordinate cannot hang the bench or the system.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 8, address bus width
TIMEOUT_CYCLES, 16, maximum wait cycles from issue to completion (≥2); counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
m_axi_clk  in  1  sole clock
m_axi_reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  completion pending
rsp_ready  in  1  completion accepted
rsp_write  out  1  completed command was a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_resp  out  2  bresp for writes, 2'b00 for reads, 2'b10 on timeout
rsp_timeout  out  1  completion was forced by timeout
m_axi_awaddr/awvalid  out  ADDR_WIDTH/1  AW channel; awready in 1
m_axi_wdata/wvalid/wlast  out  DATA_WIDTH/1/1  W channel; wready in 1
m_axi_bready  out  1; m_axi_bresp in 2; m_axi_bvalid in 1  B channel
m_axi_araddr/arvalid  out  ADDR_WIDTH/1  AR channel; arready in 1
m_axi_rready  out  1; m_axi_rdata in DATA_WIDTH; m_axi_rvalid, m_axi_rlast in 1  R channel
m_axi_rresp  out  2  constant 2'b00; the downstream subordinate takes rresp as an input

Behaviour:
- All outputs are registered. Reset values: all valid/ready outputs 0 except cmd_ready=1; all data/address/resp outputs 0; state IDLE.
- FSM states: IDLE, WR (AW/W/B in flight), RD (AR/R in flight), RSP.
- IDLE: cmd_ready=1. On cmd_valid, register address and data. A write goes to WR next cycle with awvalid=wvalid=wlast=bready=1. A read goes to RD with arvalid=rready=1. Timeout counter is cleared.
- WR: track flags aw_done, w_done, b_done.
  - awvalid drops in the cycle after the awready handshake; wvalid/wlast likewise on wready.
  - bready stays high throughout WR, so B may be accepted even before AW/W complete, because the subordinate raises bvalid off the W handshake with bready.
  - bresp is captured on the B handshake.
  - When all three flags are set → RSP.
- RD: arvalid and rready are asserted in the same cycle, because the subordinate launches rvalid only on arvalid && rready.
  - arvalid drops after the arready handshake; rready holds until the R handshake.
  - rdata is captured on the R handshake; rlast is ignored, since the transfer is single-beat.
  - Then → RSP.
- Timeout: the counter increments each cycle in WR or RD. On reaching TIMEOUT_CYCLES:
  - deassert all AXI valid/ready signals
  - rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0
  - → RSP
- A handshake completing in the same cycle the counter hits the limit wins: the transaction completes normally.
- RSP: rsp_valid=1 with stable payload until rsp_ready; on the handshake → IDLE with cmd_ready=1 next cycle, so the minimum command-to-command spacing is 4 cycles. With an always-ready subordinate the write latency is issue+2 cycles to RSP, and the read latency is issue+2.
- cmd_valid is ignored outside IDLE. No command is lost because cmd_ready=0.
- Reset mid-transaction: all AXI valid/ready outputs return to 0 in the next cycle. The in-flight command is dropped and no response is produced.
- No AXI valid is ever deasserted before its handshake, except on timeout or reset.

Decomposition:
- Package axi_mgr_pkg holds:
  - state enum (IDLE, WR, RD, RSP)
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- Single module, no sub-module; the timeout counter stays inline.

Test Plan:
- Write addr=8'h12, data=8'hA5 to the subordinate → AW/W on the same cycle, bready high; rsp_valid with rsp_write=1, rsp_resp=00, rsp_timeout=0; subordinate sees w_addr=8'h12, wdata=8'hA5.
- Read addr=8'h12 after rdata=8'h5A is applied at the subordinate → arvalid and rready coincide; rsp_rdata=8'h5A, rsp_resp=00, rsp_write=0.
- Hold rsp_ready=0 for 5 cycles after completion → rsp_valid and payload stable, cmd_ready=0 throughout; the next command is accepted only after the rsp_ready handshake.
- Model subordinate that never asserts bvalid → exactly 16 cycles after issue: rsp_timeout=1, rsp_resp=10, all AXI valids 0, FSM back to IDLE after rsp_ready.
- Assert m_axi_reset during WR with awvalid high → next cycle awvalid=wvalid=bready=0, cmd_ready=1, no rsp_valid.
- Back-to-back write then read to the same address with rsp_ready=1 → the read returns the written value.
